// File: rtl/hilo_div_ctrl.sv
// Execute-stage front end for the multi-cycle divider: issues DIV/DIVU, stalls EX
// while a divide is in flight, aborts it on flush, and owns the HI/LO registers.
module hilo_div_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [2:0]  ex_op,
   input  logic [31:0] ex_rs,
   input  logic [31:0] ex_rt,
   input  logic        flush,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_start,
   output logic        div_sign,
   output logic [31:0] div_x,
   output logic [31:0] div_y,
   output logic        div_cancel,
   input  logic [63:0] div_result,
   input  logic        div_complete
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_DIVU = 3'd2;
   localparam logic [2:0] OP_MTHI = 3'd3;
   localparam logic [2:0] OP_MTLO = 3'd4;

   state_e      state_q,     state_d;
   logic [1:0]  drain_cnt_q, drain_cnt_d;
   logic [31:0] hi_q,        hi_d;
   logic [31:0] lo_q,        lo_d;
   logic        div_start_q, div_start_d;
   logic        div_sign_q,  div_sign_d;
   logic [31:0] div_x_q,     div_x_d;
   logic [31:0] div_y_q,     div_y_d;

   logic is_div;
   logic mt_ok;
   logic stall_c;
   logic cancel_c;

   assign is_div = ex_valid && ((ex_op == OP_DIV) || (ex_op == OP_DIVU));
   // Moves to HI/LO are only honoured while no divide owns the registers.
   assign mt_ok  = ex_valid && !flush && ((state_q == S_IDLE) || (state_q == S_DRAIN));

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      div_start_d = div_start_q;
      div_sign_d  = div_sign_q;
      div_x_d     = div_x_q;
      div_y_d     = div_y_q;
      stall_c     = 1'b0;
      cancel_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (is_div && !flush) begin
               stall_c     = 1'b1;
               div_x_d     = ex_rs;
               div_y_d     = ex_rt;
               div_sign_d  = (ex_op == OP_DIV);
               div_start_d = 1'b1;
               state_d     = S_BUSY;
            end
         end
         S_BUSY: begin
            if (flush) begin
               // Flush wins over a same-cycle completion: the result is dropped.
               cancel_c    = 1'b1;
               div_start_d = 1'b0;
               drain_cnt_d = 2'd1;
               state_d     = S_DRAIN;
            end else if (div_complete) begin
               hi_d        = div_result[63:32];
               lo_d        = div_result[31:0];
               div_start_d = 1'b0;
               drain_cnt_d = 2'd0;
               state_d     = S_DRAIN;
            end else begin
               stall_c = 1'b1;
            end
         end
         S_DRAIN: begin
            div_start_d = 1'b0;
            stall_c     = is_div && !flush;
            if (drain_cnt_q == 2'd0) begin
               state_d = S_IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q - 2'd1;
            end
         end
         default: begin
            div_start_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase

      if (mt_ok && (ex_op == OP_MTHI)) hi_d = ex_rs;
      if (mt_ok && (ex_op == OP_MTLO)) lo_d = ex_rs;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= 2'd0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         div_start_q <= 1'b0;
         div_sign_q  <= 1'b0;
         div_x_q     <= 32'd0;
         div_y_q     <= 32'd0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         div_start_q <= div_start_d;
         div_sign_q  <= div_sign_d;
         div_x_q     <= div_x_d;
         div_y_q     <= div_y_d;
      end
   end

   // Combinational requests are forced low while reset is asserted.
   assign stall_req  = stall_c  && !rst;
   assign div_cancel = cancel_c && !rst;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign div_start  = div_start_q;
   assign div_sign   = div_sign_q;
   assign div_x      = div_x_q;
   assign div_y      = div_y_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: a behavioural divider stub, directed and random EX traffic,
// and a scoreboard monitor that checks HI/LO each time a divide completes or is cancelled.
module tb_hilo_div_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid, flush;
   logic [2:0]  ex_op;
   logic [31:0] ex_rs, ex_rt;
   logic        stall_req, div_start, div_sign, div_cancel, div_complete;
   logic [31:0] hi, lo, div_x, div_y;
   logic [63:0] div_result;

   typedef enum logic [1:0] {K_DONE = 2'd1, K_CANCEL = 2'd2} kind_t;
   typedef struct {
      kind_t       kind;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks   = 0;
   int          n_fail     = 0;
   int          drain_left = 0;
   logic [31:0] model_hi   = 32'd0;
   logic [31:0] model_lo   = 32'd0;

   hilo_div_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid     (ex_valid),
      .ex_op        (ex_op),
      .ex_rs        (ex_rs),
      .ex_rt        (ex_rt),
      .flush        (flush),
      .stall_req    (stall_req),
      .hi           (hi),
      .lo           (lo),
      .div_start    (div_start),
      .div_sign     (div_sign),
      .div_x        (div_x),
      .div_y        (div_y),
      .div_cancel   (div_cancel),
      .div_result   (div_result),
      .div_complete (div_complete)
   );

   always #5 clk = ~clk;

   // Architectural result of a MIPS divide: {remainder, quotient}, zero for a zero divisor.
   function automatic logic [63:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (op == 3'd1) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Divider stub: complete after 34 start-high cycles (2 for a zero divisor), held until start drops.
   logic [5:0] busy_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst)                  busy_cnt <= 6'd0;
      else if (!div_start)      busy_cnt <= 6'd0;
      else if (busy_cnt != 6'd63) busy_cnt <= busy_cnt + 6'd1;
   end
   assign div_complete = div_start && (busy_cnt >= ((div_y == 32'd0) ? 6'd2 : 6'd34));
   assign div_result   = ref_div(div_sign ? 3'd1 : 3'd2, div_x, div_y);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_hi",        hi,         32'd0);
      check("rst_lo",        lo,         32'd0);
      check("rst_div_start", div_start,  1'b0);
      check("rst_div_sign",  div_sign,   1'b0);
      check("rst_div_x",     div_x,      32'd0);
      check("rst_div_y",     div_y,      32'd0);
      check("rst_stall_req", stall_req,  1'b0);
      check("rst_div_cancel", div_cancel, 1'b0);
   endtask

   // Scoreboard monitor: on a completion or cancel cycle, compare HI/LO after the edge.
   always begin
      @(negedge clk);
      if (!rst && (div_cancel || (div_start && div_complete))) begin
         kind_t seen;
         exp_t  e;
         seen = div_cancel ? K_CANCEL : K_DONE;
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: divider event kind=%0d with empty queue", seen);
         end else begin
            e = sb_q.pop_front();
            check("sb_kind", seen, e.kind);
            check("sb_hi",   hi,   e.hi);
            check("sb_lo",   lo,   e.lo);
         end
      end
   end

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) begin
         ex_valid = 1'b0;
         ex_op    = 3'($urandom_range(0, 7));
         ex_rs    = $urandom;
         @(negedge clk);
         check("idle_stall", stall_req, 1'b0);
         @(posedge clk);
         #1;
         if (drain_left > 0) drain_left--;
      end
      check("idle_hi", hi, model_hi);
      check("idle_lo", lo, model_lo);
   endtask

   task automatic do_mt(input logic [2:0] op, input logic [31:0] v, input bit fl);
      ex_valid = 1'b1;
      ex_op    = op;
      ex_rs    = v;
      ex_rt    = $urandom;
      flush    = fl;
      @(negedge clk);
      check("mt_stall", stall_req, 1'b0);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      flush    = 1'b0;
      if (!fl && op == 3'd3) model_hi = v;
      if (!fl && op == 3'd4) model_lo = v;
      check("mt_hi", hi, model_hi);
      check("mt_lo", lo, model_lo);
      if (drain_left > 0) drain_left--;
   endtask

   // Presents a divide at cycle 0; flush_c / rst_c (>=0) kill it at that relative cycle.
   task automatic run_div(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input int flush_c, input int rst_c);
      logic [63:0] exp_res;
      exp_t        e;
      int          lat, issue, stalls, start_c;
      bit          op_bad;
      exp_res = ref_div(op, rs, rt);
      lat     = (rt == 32'd0) ? 3 : 35;
      issue   = drain_left;
      stalls  = 0;
      start_c = -1;
      op_bad  = 1'b0;
      if (rst_c < 0) begin
         e.kind = (flush_c >= 0) ? K_CANCEL : K_DONE;
         e.hi   = (flush_c >= 0) ? model_hi : exp_res[63:32];
         e.lo   = (flush_c >= 0) ? model_lo : exp_res[31:0];
         sb_q.push_back(e);
      end
      ex_valid = 1'b1;
      ex_op    = op;
      ex_rs    = rs;
      ex_rt    = rt;
      for (int c = 0; c < 200; c++) begin
         flush = (c == flush_c);
         if (c == rst_c) begin
            rst = 1'b1;
            #1;
            check_reset_outputs();
            ex_valid   = 1'b0;
            flush      = 1'b0;
            sb_q.delete();
            model_hi   = 32'd0;
            model_lo   = 32'd0;
            drain_left = 0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            return;
         end
         @(negedge clk);
         if (div_start) begin
            if (start_c < 0) start_c = c;
            if (div_x !== rs || div_y !== rt || div_sign !== (op == 3'd1)) op_bad = 1'b1;
         end
         check("div_cancel", div_cancel, (c == flush_c));
         if (!stall_req) break;
         stalls++;
         @(posedge clk);
         #1;
      end
      check("div_stall_cycles", stalls, (flush_c >= 0) ? flush_c : issue + lat);
      check("div_start_cycle",  start_c, issue + 1);
      check("div_operands_stable", op_bad, 1'b0);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      flush    = 1'b0;
      if (flush_c >= 0) begin
         drain_left = 2;
      end else begin
         model_hi   = exp_res[63:32];
         model_lo   = exp_res[31:0];
         drain_left = 1;
      end
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] rs, rt;
      int          fc, lat, sel;
      ex_valid = 1'b0;
      ex_op    = 3'd0;
      ex_rs    = 32'd0;
      ex_rt    = 32'd0;
      flush    = 1'b0;
      #2;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_idle(2);

      run_div(3'd1, 32'hFFFF_FFF9, 32'd2, -1, -1);
      check("neg7_lo", lo, 32'hFFFF_FFFD);
      check("neg7_hi", hi, 32'hFFFF_FFFF);
      run_idle(1);

      run_div(3'd2, 32'd100, 32'd7, -1, -1);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);
      do_mt(3'd3, 32'hCAFE_F00D, 1'b0);
      check("mthi_in_drain", hi, 32'hCAFE_F00D);
      run_idle(2);

      do_mt(3'd3, 32'hDEAD_BEEF, 1'b0);
      do_mt(3'd4, 32'h1234_5678, 1'b0);
      check("mthi_hi", hi, 32'hDEAD_BEEF);
      check("mtlo_lo", lo, 32'h1234_5678);
      do_mt(3'd3, 32'h5555_5555, 1'b1);
      check("mthi_flushed", hi, 32'hDEAD_BEEF);

      run_div(3'd1, 32'd5, 32'd0, -1, -1);
      check("div0_hi", hi, 32'd0);
      check("div0_lo", lo, 32'd0);

      do_mt(3'd3, 32'hA5A5_A5A5, 1'b0);
      do_mt(3'd4, 32'h5A5A_5A5A, 1'b0);
      run_idle(2);
      run_div(3'd1, 32'd1000, 32'd3, 10, -1);
      check("flush_start_low", div_start, 1'b0);
      check("flush_hi_kept", hi, 32'hA5A5_A5A5);
      check("flush_lo_kept", lo, 32'h5A5A_5A5A);
      run_div(3'd2, 32'd9, 32'd2, -1, -1);
      check("after_flush_lo", lo, 32'd4);
      check("after_flush_hi", hi, 32'd1);

      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) begin
            op = 3'($urandom_range(1, 2));
            rs = $urandom;
            if ($urandom_range(0, 7) == 0)      rt = 32'd0;
            else if ($urandom_range(0, 1) == 0) rt = $urandom;
            else                                rt = $urandom_range(1, 20);
            if (op == 3'd1 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
            lat = (rt == 32'd0) ? 3 : 35;
            fc  = ($urandom_range(0, 4) == 0) ? drain_left + int'($urandom_range(1, lat)) : -1;
            run_div(op, rs, rt, fc, -1);
         end else if (sel < 9) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd1 || op == 3'd2) op = 3'd3;
            do_mt(op, $urandom, ($urandom_range(0, 5) == 0));
         end else begin
            run_idle($urandom_range(1, 3));
         end
      end

      run_idle(3);
      run_div(3'd1, 32'h0000_1234, 32'd5, -1, 20);
      run_div(3'd1, 32'd10, 32'd3, -1, -1);
      check("post_reset_lo", lo, 32'd3);
      check("post_reset_hi", hi, 32'd1);
      run_idle(2);
      check("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
